controle_multiciclo: RTL and testbench

CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

---
 rtl/controle_multiciclo.sv | 178 +++++++++++++++++
 tb/tb_controle_multiciclo.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/controle_multiciclo.sv
// Multi-cycle MIPS-style control unit: Moore FSM driving datapath controls
// plus a retired-instruction counter.
module controle_multiciclo #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         operacao,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ALUSrcB,
  output logic [3:0]         estado,
  output logic               erro,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11,
    ILLEGAL   = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t             state_q, state_d;
  logic [5:0]         op_q, op_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = FETCH;
    op_d        = op_q;
    retire      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    erro        = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        state_d = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        op_d    = operacao;
        unique case (1'b1)
          operacao == OP_R:    state_d = R_EXEC;
          operacao == OP_LW,
          operacao == OP_SW:   state_d = MEM_ADDR;
          operacao == OP_BEQ:  state_d = BRANCH;
          operacao == OP_J:    state_d = JUMP;
          operacao == OP_ADDI: state_d = ADDI_EXEC;
          default:             state_d = ILLEGAL;
        endcase
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (op_q == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
      end
      MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        retire   = mem_ready;
        state_d  = mem_ready ? FETCH : MEM_WRITE;
      end
      R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = R_WB;
      end
      R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        retire   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        retire      = 1'b1;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        retire   = 1'b1;
      end
      ADDI_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = ADDI_WB;
      end
      ADDI_WB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      ILLEGAL: erro = 1'b1;
      default: state_d = FETCH;
    endcase
    cnt_d = cnt_q + {{(COUNT_W-1){1'b0}}, retire};
    // Held in reset the FSM sits in FETCH, so mask its enables off.
    if (!rst_n) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
      erro        = 1'b0;
    end
  end

  assign estado      = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: vector table plus reset
// and counter-wrap sequences.
module tb_controle_multiciclo;

  logic        clk;
  logic        rst_n;
  logic [5:0]  operacao;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic        MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0]  PCSource, ALUOp, ALUSrcB;
  logic [3:0]  estado;
  logic        erro;
  logic [15:0] instr_count;

  logic        rst2_n;
  logic [5:0]  op2;
  logic        mr2;
  logic        w_pcw, w_pcwc, w_iord, w_mr, w_mw, w_m2r, w_irw;
  logic        w_asa, w_rw, w_rd, w_err;
  logic [1:0]  w_pcs, w_aop, w_asb;
  logic [3:0]  est2;
  logic [3:0]  cnt2;

  int checks = 0;
  int errors = 0;

  controle_multiciclo dut (
    .clk(clk), .rst_n(rst_n), .operacao(operacao),
    .mem_ready(mem_ready), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite),
    .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
    .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .estado(estado), .erro(erro), .instr_count(instr_count)
  );

  controle_multiciclo #(.COUNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst2_n), .operacao(op2),
    .mem_ready(mr2), .PCWrite(w_pcw),
    .PCWriteCond(w_pcwc), .IorD(w_iord), .MemRead(w_mr),
    .MemWrite(w_mw), .MemtoReg(w_m2r), .IRWrite(w_irw),
    .ALUSrcA(w_asa), .RegWrite(w_rw), .RegDst(w_rd),
    .PCSource(w_pcs), .ALUOp(w_aop), .ALUSrcB(w_asb),
    .estado(est2), .erro(w_err), .instr_count(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  vec_t vq[$];

  // Control bundle: PCW,PCWC,IorD,MR | MW,M2R,IRW,ASA | RW,RD,PCS | AOP,ASB
  localparam logic [15:0] C_RST  = 16'h0001;
  localparam logic [15:0] C_F1   = 16'h9201;
  localparam logic [15:0] C_F0   = 16'h1001;
  localparam logic [15:0] C_DEC  = 16'h0003;
  localparam logic [15:0] C_MA   = 16'h0102;
  localparam logic [15:0] C_MRD  = 16'h3000;
  localparam logic [15:0] C_MWB  = 16'h0480;
  localparam logic [15:0] C_MWR  = 16'h2800;
  localparam logic [15:0] C_REX  = 16'h0108;
  localparam logic [15:0] C_RWB  = 16'h00C0;
  localparam logic [15:0] C_BR   = 16'h4114;
  localparam logic [15:0] C_J    = 16'h8020;
  localparam logic [15:0] C_AWB  = 16'h0080;
  localparam logic [15:0] C_NONE = 16'h0000;

  function automatic logic [15:0] ctl_now();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
            IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB};
  endfunction

  task automatic add(input logic r, input logic [5:0] o, input logic m,
                     input logic [3:0] s, input logic [15:0] c,
                     input logic e, input logic [15:0] n);
    vec_t v;
    v.rst = r; v.op = o; v.mr = m; v.st = s;
    v.ctl = c; v.err = e; v.cnt = n;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst_n = v.rst; operacao = v.op; mem_ready = v.mr;
    #1;
    chk($sformatf("v%0d estado", idx), 32'(estado), 32'(v.st));
    chk($sformatf("v%0d ctl", idx), 32'(ctl_now()), 32'(v.ctl));
    chk($sformatf("v%0d erro", idx), 32'(erro), 32'(v.err));
    chk($sformatf("v%0d count", idx), 32'(instr_count), 32'(v.cnt));
  endtask

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] RT = 6'b000000, BQ = 6'b000100;
  localparam logic [5:0] JP = 6'b000010, AI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  initial begin
    vec_t v;
    rst_n = 1'b0; operacao = '0; mem_ready = 1'b1;
    rst2_n = 1'b0; op2 = JP; mr2 = 1'b1;

    add(0, LW, 1, 0, C_RST, 0, 0);
    add(0, LW, 0, 0, C_RST, 0, 0);
    // lw; opcode changed during MEM_ADDR must not divert it
    add(1, LW, 1, 0, C_F1,  0, 0);
    add(1, LW, 1, 1, C_DEC, 0, 0);
    add(1, SW, 1, 2, C_MA,  0, 0);
    add(1, SW, 1, 3, C_MRD, 0, 0);
    add(1, SW, 1, 4, C_MWB, 0, 0);
    // sw with three stall cycles
    add(1, SW, 1, 0, C_F1,  0, 1);
    add(1, SW, 1, 1, C_DEC, 0, 1);
    add(1, SW, 1, 2, C_MA,  0, 1);
    add(1, SW, 0, 5, C_MWR, 0, 1);
    add(1, SW, 0, 5, C_MWR, 0, 1);
    add(1, SW, 0, 5, C_MWR, 0, 1);
    add(1, SW, 1, 5, C_MWR, 0, 1);
    // fetch stall, then R-type with mem_ready ignored
    add(1, RT, 0, 0, C_F0,  0, 2);
    add(1, RT, 1, 0, C_F1,  0, 2);
    add(1, RT, 0, 1, C_DEC, 0, 2);
    add(1, RT, 0, 6, C_REX, 0, 2);
    add(1, RT, 0, 7, C_RWB, 0, 2);
    add(1, BQ, 1, 0, C_F1,  0, 3);
    add(1, BQ, 1, 1, C_DEC, 0, 3);
    add(1, BQ, 1, 8, C_BR,  0, 3);
    add(1, JP, 1, 0, C_F1,  0, 4);
    add(1, JP, 1, 1, C_DEC, 0, 4);
    add(1, JP, 1, 9, C_J,   0, 4);
    add(1, AI, 1, 0, C_F1,  0, 5);
    add(1, AI, 1, 1, C_DEC, 0, 5);
    add(1, AI, 1, 10, C_MA, 0, 5);
    add(1, AI, 1, 11, C_AWB, 0, 5);
    add(1, BAD, 1, 0, C_F1,  0, 6);
    add(1, BAD, 1, 1, C_DEC, 0, 6);
    add(1, BAD, 1, 12, C_NONE, 1, 6);
    add(1, LW, 1, 0, C_F1,  0, 6);
    add(1, LW, 1, 1, C_DEC, 0, 6);
    add(1, LW, 0, 2, C_MA,  0, 6);
    add(1, LW, 0, 3, C_MRD, 0, 6);

    foreach (vq[i]) apply(vq[i], i);

    // Asynchronous reset during a MEM_READ stall
    #2 rst_n = 1'b0;
    #1;
    chk("rst estado", 32'(estado), 32'd0);
    chk("rst ctl", 32'(ctl_now()), 32'(C_RST));
    chk("rst erro", 32'(erro), 32'd0);
    chk("rst count", 32'(instr_count), 32'd0);
    v.rst = 1; v.op = LW; v.mr = 0; v.st = 0;
    v.ctl = C_F0; v.err = 0; v.cnt = 0;
    apply(v, 100);
    v.mr = 1; v.ctl = C_F1;
    apply(v, 101);
    v.st = 1; v.ctl = C_DEC;
    apply(v, 102);

    // Narrow counter wraps after 16 jumps
    @(negedge clk);
    rst2_n = 1'b1;
    for (int j = 0; j < 16; j++) begin
      repeat (3) @(negedge clk);
      #1;
      chk($sformatf("wrap j%0d count", j), 32'(cnt2),
          32'((j + 1) % 16));
      chk($sformatf("wrap j%0d estado", j), 32'(est2), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
